// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game controller and its neighbours:
// ball/button events in, score strobes and overlay status out.
interface pong_game_ctrl_if;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       d_inc;
    logic       d_clr;
    logic       gra_still;
    logic [1:0] game_state;
    logic [1:0] balls_left;

    modport master (
        output refr_tick, btn, hit, miss,
        input  d_inc, d_clr, gra_still, game_state, balls_left
    );

    modport slave (
        input  refr_tick, btn, hit, miss,
        output d_inc, d_clr, gra_still, game_state, balls_left
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-control FSM: drives score-counter strobes, tracks balls
// remaining, and times the between-ball / game-over pauses.
module pong_game_ctrl #(
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120,
    parameter int TW          = 7
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_TICKS);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

    state_t        state_q, state_d;
    logic [1:0]    balls_q, balls_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          btn_q;
    logic          d_inc_q, d_inc_d;
    logic          press;
    logic          timer_start;
    logic          timer_up;

    // btn_q resets high so a button held through reset is not a press
    assign press    = (|bus.btn) & ~btn_q;
    assign timer_up = (timer_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NEWGAME;
            balls_q <= BALLS_INIT;
            timer_q <= '0;
            btn_q   <= 1'b1;
            d_inc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            balls_q <= balls_d;
            timer_q <= timer_d;
            btn_q   <= |bus.btn;
            d_inc_q <= d_inc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        balls_d     = balls_q;
        d_inc_d     = 1'b0;
        timer_start = 1'b0;
        unique case (state_q)
            NEWGAME: begin
                balls_d = BALLS_INIT;
                if (press) begin
                    state_d = PLAY;
                    balls_d = BALLS_INIT - 2'd1;
                end
            end
            PLAY: begin
                if (bus.miss) begin
                    timer_start = 1'b1;
                    if (balls_q == '0) begin
                        state_d = OVER;
                    end else begin
                        state_d = NEWBALL;
                        balls_d = balls_q - 2'd1;
                    end
                end else if (bus.hit) begin
                    d_inc_d = 1'b1;
                end
            end
            NEWBALL: begin
                if (timer_up && press) state_d = PLAY;
            end
            OVER: begin
                // refill on the transition edge so NEWGAME shows a full stock at once
                if (timer_up) begin
                    state_d = NEWGAME;
                    balls_d = BALLS_INIT;
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (timer_start)
            timer_d = TIMER_LOAD;
        else if (bus.refr_tick && !timer_up)
            timer_d = timer_q - TIMER_ONE;
    end

    assign bus.d_inc      = d_inc_q;
    assign bus.d_clr      = (state_q == NEWGAME);
    assign bus.gra_still  = (state_q != PLAY);
    assign bus.game_state = state_q;
    assign bus.balls_left = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with hand-computed
// expectations, driven through the controller interface.
module tb_pong_game_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   inc_cnt;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .BALLS       (3),
        .TIMER_TICKS (120),
        .TW          (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.d_inc === 1'b1) inc_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.refr_tick = 1'b1;
            tick();
            bus.refr_tick = 1'b0;
            tick();
        end
    endtask

    task automatic press_btn(input logic [1:0] b);
        bus.btn = b;
        tick();
        bus.btn = 2'b00;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; inc_cnt = 0;
        reset = 1'b1;
        bus.refr_tick = 1'b0; bus.btn = 2'b00; bus.hit = 1'b0; bus.miss = 1'b0;
        tick(); tick();
        check("rst_state", 8'(bus.game_state), 8'h0);
        check("rst_dclr",  8'(bus.d_clr), 8'h1);
        check("rst_still", 8'(bus.gra_still), 8'h1);
        check("rst_dinc",  8'(bus.d_inc), 8'h0);
        check("rst_balls", 8'(bus.balls_left), 8'h3);

        // reset then start
        reset = 1'b0;
        repeat (5) tick();
        check("idle_dclr",  8'(bus.d_clr), 8'h1);
        check("idle_state", 8'(bus.game_state), 8'h0);
        bus.btn = 2'b01;
        tick();
        check("start_state", 8'(bus.game_state), 8'h1);
        check("start_balls", 8'(bus.balls_left), 8'h2);
        check("start_still", 8'(bus.gra_still), 8'h0);
        check("start_dclr",  8'(bus.d_clr), 8'h0);
        bus.btn = 2'b00;
        tick();

        // scoring: three back-to-back hits, then one more later
        inc_cnt = 0;
        bus.hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hit_burst_dinc", 8'(bus.d_inc), 8'h1);
        end
        bus.hit = 1'b0;
        tick();
        check("hit_burst_end", 8'(bus.d_inc), 8'h0);
        repeat (9) tick();
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        check("hit_late_dinc", 8'(bus.d_inc), 8'h1);
        tick();
        check("hit_late_end", 8'(bus.d_inc), 8'h0);
        check("hit_count", 8'(inc_cnt), 8'd4);

        // miss and relaunch
        bus.miss = 1'b1;
        tick();
        bus.miss = 1'b0;
        check("miss1_state", 8'(bus.game_state), 8'h2);
        check("miss1_balls", 8'(bus.balls_left), 8'h1);
        check("miss1_still", 8'(bus.gra_still), 8'h1);
        frames(60);
        press_btn(2'b01);
        check("early_press60", 8'(bus.game_state), 8'h2);
        frames(59);
        press_btn(2'b01);
        check("early_press119", 8'(bus.game_state), 8'h2);
        frames(1);
        bus.btn = 2'b01;
        tick();
        check("relaunch_state", 8'(bus.game_state), 8'h1);
        check("relaunch_still", 8'(bus.gra_still), 8'h0);
        bus.btn = 2'b00;
        tick();

        // simultaneous hit and miss: miss wins, no score
        inc_cnt = 0;
        bus.hit = 1'b1; bus.miss = 1'b1;
        tick();
        bus.hit = 1'b0; bus.miss = 1'b0;
        check("hm_dinc",  8'(bus.d_inc), 8'h0);
        check("hm_state", 8'(bus.game_state), 8'h2);
        check("hm_balls", 8'(bus.balls_left), 8'h0);
        tick();
        check("hm_count", 8'(inc_cnt), 8'd0);
        frames(120);
        bus.btn = 2'b10;
        tick();
        check("relaunch2_state", 8'(bus.game_state), 8'h1);
        bus.btn = 2'b00;
        tick();

        // game over on last ball
        bus.miss = 1'b1;
        tick();
        bus.miss = 1'b0;
        check("over_state", 8'(bus.game_state), 8'h3);
        check("over_dclr",  8'(bus.d_clr), 8'h0);
        check("over_balls", 8'(bus.balls_left), 8'h0);
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        tick();
        check("over_hit_ignored", 8'(bus.d_inc), 8'h0);
        frames(119);
        check("over_hold119", 8'(bus.game_state), 8'h3);
        frames(1);
        check("newgame_state", 8'(bus.game_state), 8'h0);
        check("newgame_dclr",  8'(bus.d_clr), 8'h1);
        check("newgame_balls", 8'(bus.balls_left), 8'h3);

        // reset mid-play with a held button
        press_btn(2'b01);
        check("play2_state", 8'(bus.game_state), 8'h1);
        bus.btn = 2'b10;
        tick();
        reset = 1'b1;
        #1;
        check("areset_state", 8'(bus.game_state), 8'h0);
        check("areset_dclr",  8'(bus.d_clr), 8'h1);
        check("areset_balls", 8'(bus.balls_left), 8'h3);
        check("areset_dinc",  8'(bus.d_inc), 8'h0);
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
        check("held_no_press", 8'(bus.game_state), 8'h0);
        bus.btn = 2'b00;
        tick();
        bus.btn = 2'b10;
        tick();
        check("repress_state", 8'(bus.game_state), 8'h1);
        check("repress_balls", 8'(bus.balls_left), 8'h2);
        bus.btn = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-control state machine for the Pong VGA design. It sits directly upstream of the two-digit BCD score counter. It issues the counter's increment (`d_inc`) and clear (`d_clr`) strobes from ball hit/miss events and player button presses. It also tracks balls remaining, runs the between-ball and game-over delay, and tells the graphics stage when to freeze the ball.

## Interface
Parameters:
- `BALLS`, default 3: balls per game. Range 1..3.
- `TIMER_TICKS`, default 120: delay length in `refr_tick` pulses (2 s at 60 Hz). Must be < 2^`TW`.
- `TW`, default 7: delay timer width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `refr_tick`  in  1  one-cycle pulse per video frame.
- `btn`  in  2  debounced player buttons. Any nonzero value counts as pressed.
- `hit`  in  1  one-cycle pulse: ball struck a paddle.
- `miss`  in  1  one-cycle pulse: ball passed a paddle.
- `d_inc`  out  1  score increment strobe to the score counter.
- `d_clr`  out  1  score clear to the score counter.
- `gra_still`  out  1  1 = graphics holds the ball stationary.
- `game_state`  out  2  current state code, for text overlay selection.
- `balls_left`  out  2  balls remaining after the one in play.

## Operation
- Press detect:
  - `press` = (|`btn`) & ~`btn_q`, where `btn_q` is the registered |`btn`.
  - `btn_q` resets to 1, so a button held through reset produces no press until it is released.
- Delay timer (`TW` bits):
  - Loads `TIMER_TICKS` on `timer_start`.
  - Otherwise decrements on `refr_tick` while nonzero.
  - `timer_up` = (timer == 0).
  - Load wins over decrement in the same cycle.
  - Resets to 0.
- States and codes:
  - NEWGAME = 00, PLAY = 01, NEWBALL = 10, OVER = 11.
  - Reset state is NEWGAME.
- NEWGAME:
  - `gra_still`=1, `d_clr`=1, `balls_left` held at `BALLS`.
  - On `press`: go to PLAY and set `balls_left` = `BALLS`-1.
- PLAY:
  - `gra_still`=0.
  - `hit` without `miss`: `d_inc` pulses.
  - `miss` with `balls_left`==0: go to OVER and assert `timer_start`.
  - `miss` with `balls_left`!=0: go to NEWBALL, decrement `balls_left` and assert `timer_start`.
  - `miss` has priority over a simultaneous `hit`; no `d_inc` is issued in that case.
- NEWBALL:
  - `gra_still`=1.
  - Requires `timer_up` & `press` in the same cycle to go to PLAY.
  - A press before expiry is ignored; the player must press again.
- OVER:
  - `gra_still`=1.
  - On `timer_up`: go to NEWGAME.
  - The score is not cleared until NEWGAME is entered.
- `hit` and `miss` outside PLAY are ignored.
- `balls_left` never wraps below 0.

## Timing
- All outputs are registered.
- Reset values:
  - `d_inc`=0, `d_clr`=1, `gra_still`=1.
  - `game_state`=00, `balls_left`=`BALLS`, timer=0.
- `d_inc`:
  - One-cycle pulse in cycle N+1 for a `hit` sampled at edge N.
  - The score counter updates at edge N+2.
- `d_clr`, `gra_still` and `game_state` follow the state register. They change in the cycle after the transition edge.
- `balls_left` updates on the same edge as the PLAY→NEWBALL or NEWGAME→PLAY transition.
- Timer:
  - The load takes effect at the transition edge.
  - `timer_up` is first seen exactly `TIMER_TICKS` `refr_tick` pulses later.
- Back-to-back `hit` pulses on consecutive cycles produce consecutive `d_inc` pulses. No merging.
- Asserting `reset` mid-game returns immediately to NEWGAME with a score clear. No partial strobes are emitted.

## Test plan
- Reset then start:
  - Stimulus: release reset with `btn`=00, wait 5 cycles, pulse `btn`=01.
  - Required: `d_clr`=1 until press; `game_state` goes 00→01 the next cycle; `balls_left`=2; `gra_still`=0.
- Scoring:
  - Stimulus: in PLAY, pulse `hit` on 3 consecutive cycles, then once more 10 cycles later.
  - Required: exactly 4 `d_inc` pulses, each 1 cycle after its `hit`.
- Miss and relaunch:
  - Stimulus: in PLAY with `balls_left`=2, pulse `miss`; press at tick 60; press again after 120 `refr_tick`s.
  - Required: NEWBALL, `balls_left`=1, `gra_still`=1; first press ignored; second press returns to PLAY.
- Simultaneous hit and miss:
  - Stimulus: `hit`=`miss`=1 in the same cycle in PLAY.
  - Required: no `d_inc`; transition to NEWBALL.
- Game over:
  - Stimulus: miss with `balls_left`=0, then 120 `refr_tick`s.
  - Required: OVER (11) with `d_clr`=0; then NEWGAME with `d_clr`=1 and `balls_left`=3.
- Reset and held button:
  - Stimulus: assert `reset` mid-PLAY while `btn`=10 is held; release `btn` after reset deasserts, then press.
  - Required: NEWGAME immediately; no press while held through reset; the new press starts the game.
